lcd_bus_responder: RTL and testbench



---
 rtl/lcd_bus_responder.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// +--------------------------------------------------------------------------+
// | lcd_bus_responder : HD44780-style LCD bus far end with DDRAM image,      |
// |                     busy-flag emulation and debug peek port.  Rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  lcd_data,
  input  logic [4:0]  lcd_ctrl,
  output logic [7:0]  lcd_rdata,
  input  logic [6:0]  peek_addr,
  output logic [7:0]  peek_data,
  output logic        busy,
  output logic [6:0]  ac,
  output logic        display_on,
  output logic        cursor_on,
  output logic        blink_on,
  output logic        inc_mode,
  output logic        two_line,
  output logic [15:0] xfer_count,
  output logic        err_overrun,
  output logic        err_addr
);

  localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);
  localparam logic [CW-1:0] ONE        = CW'(1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_BUSY     = 2'd1;
  localparam logic [1:0] S_CLEARING = 2'd2;

  // Address counter walks the two 40-column lines as one 80-entry ring.
  function automatic logic [6:0] step_ac(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic is_mapped(input logic [6:0] a);
    return a[5:0] < 6'd40;
  endfunction

  function automatic logic [6:0] ddram_index(input logic [6:0] a);
    return a[6] ? ({1'b0, a[5:0]} + 7'd40) : {1'b0, a[5:0]};
  endfunction

  logic [7:0]    ddram [0:79];
  logic [7:0]    data_q;
  logic          rs_q, rw_q, e_q;
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [6:0]    fill_idx;
  logic          dl_flag, shift_flag, cgram_mode;

  logic strobe, take, accept, overrun, do_clear, do_load;
  logic is_write, is_instr, is_dread, data_we, fill_we;

  assign busy     = (count != '0);
  assign strobe   = e_q & ~lcd_ctrl[2];
  assign take     = strobe & lcd_ctrl[3];
  assign accept   = take & ~busy;
  assign is_write = ~rw_q & rs_q;
  assign is_instr = ~rw_q & ~rs_q;
  assign is_dread = rw_q & rs_q;
  // Reads never count as overruns: polling the busy flag is the normal use.
  assign overrun  = take & busy & ~rw_q;
  assign do_clear = accept & is_instr & (data_q == 8'h01);
  assign do_load  = accept & ~rw_q;
  assign fill_we  = (state == S_CLEARING);
  assign data_we  = accept & is_write & ~cgram_mode;

  logic unused_ok;
  assign unused_ok = &{1'b0, lcd_ctrl[4], dl_flag, shift_flag};

  always_ff @(posedge clock) begin
    if (fill_we)      ddram[fill_idx]         <= 8'h20;
    else if (data_we) ddram[ddram_index(ac)]  <= data_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      e_q         <= 1'b0;
      state       <= S_CLEARING;
      count       <= CLEAR_LOAD;
      fill_idx    <= 7'd0;
      ac          <= 7'h00;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      inc_mode    <= 1'b1;
      shift_flag  <= 1'b0;
      two_line    <= 1'b0;
      dl_flag     <= 1'b1;
      cgram_mode  <= 1'b0;
      xfer_count  <= 16'h0000;
      err_overrun <= 1'b0;
      err_addr    <= 1'b0;
      peek_data   <= 8'h00;
    end else begin
      data_q <= lcd_data;
      rs_q   <= lcd_ctrl[0];
      rw_q   <= lcd_ctrl[1];
      e_q    <= lcd_ctrl[2];

      peek_data <= is_mapped(peek_addr) ? ddram[ddram_index(peek_addr)] : 8'h00;

      if (do_clear)     count <= CLEAR_LOAD;
      else if (do_load) count <= BUSY_LOAD;
      else if (busy)    count <= count - ONE;

      if (accept && xfer_count != 16'hFFFF) xfer_count <= xfer_count + 16'd1;
      if (overrun) err_overrun <= 1'b1;

      case (state)
        S_IDLE, S_BUSY: begin
          if (do_clear) begin
            state    <= S_CLEARING;
            fill_idx <= 7'd0;
          end else if (do_load) begin
            state <= S_BUSY;
          end else if (!busy) begin
            state <= S_IDLE;
          end
        end
        S_CLEARING: begin
          fill_idx <= fill_idx + 7'd1;
          if (fill_idx == 7'd79) state <= (count > ONE) ? S_BUSY : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (do_clear) begin
        ac         <= 7'h00;
        inc_mode   <= 1'b1;
        cgram_mode <= 1'b0;
      end else if (accept) begin
        if (is_write || is_dread) begin
          ac <= step_ac(ac, inc_mode);
        end else if (is_instr) begin
          casez (data_q)
            8'b1???????: begin
              cgram_mode <= 1'b0;
              if (is_mapped(data_q[6:0])) begin
                ac <= data_q[6:0];
              end else begin
                ac       <= 7'h00;
                err_addr <= 1'b1;
              end
            end
            8'b01??????: cgram_mode <= 1'b1;
            8'b001?????: begin
              dl_flag  <= data_q[4];
              two_line <= data_q[3];
            end
            8'b0001????: if (!data_q[3]) ac <= step_ac(ac, data_q[2]);
            8'b00001???: begin
              display_on <= data_q[2];
              cursor_on  <= data_q[1];
              blink_on   <= data_q[0];
            end
            8'b000001??: begin
              inc_mode   <= data_q[1];
              shift_flag <= data_q[0];
            end
            8'b0000001?: ac <= 7'h00;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    lcd_rdata = 8'h00;
    if (lcd_ctrl[2] && lcd_ctrl[1])
      lcd_rdata = lcd_ctrl[0] ? ddram[ddram_index(ac)] : {busy, ac};
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: directed literal checks plus random traffic
// compared every cycle against a ring-buffer model of the LCD.
`default_nettype none

module tb_lcd_bus_responder;

  localparam int BC = 20;
  localparam int CC = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  lcd_data = 8'h00;
  logic        rs_i = 1'b0, rw_i = 1'b0, e_i = 1'b0, on_i = 1'b1;
  logic [4:0]  lcd_ctrl;
  logic [7:0]  lcd_rdata;
  logic [6:0]  peek_addr = 7'h00;
  logic [7:0]  peek_data;
  logic        busy;
  logic [6:0]  ac;
  logic        display_on, cursor_on, blink_on, inc_mode, two_line;
  logic [15:0] xfer_count;
  logic        err_overrun, err_addr;

  assign lcd_ctrl = {1'b1, on_i, e_i, rw_i, rs_i};

  lcd_bus_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
    .clock(clock), .reset(reset), .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl),
    .lcd_rdata(lcd_rdata), .peek_addr(peek_addr), .peek_data(peek_data),
    .busy(busy), .ac(ac), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .inc_mode(inc_mode), .two_line(two_line),
    .xfer_count(xfer_count), .err_overrun(err_overrun), .err_addr(err_addr)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: display as an 80-cell ring ----------
  logic [7:0] mem [80];
  bit         known [80];
  logic [6:0] m_ac;
  bit         m_disp, m_cur, m_blink, m_inc, m_two, m_cg, m_eo, m_ea;
  int         m_cnt, m_fill, m_xfer;
  logic [7:0] m_peek;
  bit         m_peek_known;
  logic [7:0] p_data;
  bit         p_rs, p_rw, p_e;

  function automatic bit mapped(input logic [6:0] a);
    return a[5:0] < 6'd40;
  endfunction
  function automatic int lin(input logic [6:0] a);
    return (a[6] ? 40 : 0) + int'(a[5:0]);
  endfunction
  function automatic logic [6:0] addr_of(input int p);
    return (p < 40) ? 7'(p) : 7'(p + 24);
  endfunction
  function automatic logic [6:0] step(input logic [6:0] a, input bit up);
    return addr_of((lin(a) + (up ? 1 : 79)) % 80);
  endfunction

  initial for (int i = 0; i < 80; i++) known[i] = 1'b0;

  // While reset is held the clear sequence sits on its first cell.
  always @(posedge clock) if (!reset) begin
    mem[0] = 8'h20;
    known[0] = 1'b1;
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ac = 7'h00; m_disp = 0; m_cur = 0; m_blink = 0; m_inc = 1; m_two = 0;
      m_cg = 0; m_eo = 0; m_ea = 0; m_cnt = CC; m_fill = 0; m_xfer = 0;
      m_peek = 8'h00; m_peek_known = 1; p_data = 8'h00; p_rs = 0; p_rw = 0; p_e = 0;
    end else begin
      bit was_busy;
      if (mapped(peek_addr)) begin
        m_peek = mem[lin(peek_addr)];
        m_peek_known = known[lin(peek_addr)];
      end else begin
        m_peek = 8'h00;
        m_peek_known = 1;
      end
      was_busy = (m_cnt > 0);
      if (m_fill < 80) begin
        mem[m_fill] = 8'h20;
        known[m_fill] = 1;
        m_fill++;
      end
      if (m_cnt > 0) m_cnt--;
      if (p_e && !lcd_ctrl[2] && lcd_ctrl[3]) begin
        if (was_busy) begin
          if (!p_rw) m_eo = 1;
        end else begin
          if (m_xfer < 65535) m_xfer++;
          if (p_rw) begin
            if (p_rs) m_ac = step(m_ac, m_inc);
          end else if (p_rs) begin
            m_cnt = BC;
            if (!m_cg) begin
              mem[lin(m_ac)] = p_data;
              known[lin(m_ac)] = 1;
            end
            m_ac = step(m_ac, m_inc);
          end else begin
            m_cnt = BC;
            if (p_data >= 128) begin
              m_cg = 0;
              if (mapped(p_data[6:0])) m_ac = p_data[6:0];
              else begin m_ac = 7'h00; m_ea = 1; end
            end
            else if (p_data >= 64) m_cg = 1;
            else if (p_data >= 32) m_two = p_data[3];
            else if (p_data >= 16) begin if (!p_data[3]) m_ac = step(m_ac, p_data[2]); end
            else if (p_data >= 8) begin m_disp = p_data[2]; m_cur = p_data[1]; m_blink = p_data[0]; end
            else if (p_data >= 4) m_inc = p_data[1];
            else if (p_data >= 2) m_ac = 7'h00;
            else if (p_data == 1) begin
              m_ac = 7'h00; m_inc = 1; m_cg = 0; m_cnt = CC; m_fill = 0;
            end
          end
        end
      end
      p_e = lcd_ctrl[2]; p_data = lcd_data; p_rs = lcd_ctrl[0]; p_rw = lcd_ctrl[1];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    logic [7:0] exp_rd;
    bit rd_known;
    check("status", {busy, ac, display_on, cursor_on, blink_on, inc_mode, two_line,
                     xfer_count, err_overrun, err_addr},
          {(m_cnt > 0), m_ac, m_disp, m_cur, m_blink, m_inc, m_two, 16'(m_xfer), m_eo, m_ea});
    if (m_peek_known) check("peek_data", peek_data, m_peek);
    exp_rd = 8'h00;
    rd_known = 1;
    if (e_i && rw_i) begin
      if (rs_i) begin
        exp_rd = mem[lin(m_ac)];
        rd_known = known[lin(m_ac)];
      end else exp_rd = {(m_cnt > 0), m_ac};
    end
    if (rd_known) check("lcd_rdata", lcd_rdata, exp_rd);
  end

  // ---------------- stimulus ----------------
  task automatic xfer(input bit rs, input bit rw, input logic [7:0] d);
    @(posedge clock); #1;
    lcd_data = d; rs_i = rs; rw_i = rw; e_i = 1'b1;
    @(posedge clock); #1;
    e_i = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic read_xfer(input bit rs, output logic [7:0] rd);
    @(posedge clock); #1;
    rs_i = rs; rw_i = 1'b1; e_i = 1'b1;
    #1 rd = lcd_rdata;
    @(posedge clock); #1;
    e_i = 1'b0;
    @(posedge clock); #1;
    rw_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int i;
    i = 0;
    while (busy === 1'b1 && i < limit) begin
      @(posedge clock); #1;
      i++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic cmd(input logic [7:0] d);
    wait_idle(CC + 20);
    xfer(1'b0, 1'b0, d);
  endtask

  task automatic wr(input logic [7:0] d);
    wait_idle(CC + 20);
    xfer(1'b1, 1'b0, d);
  endtask

  task automatic peek_chk(input string name, input logic [6:0] a, input logic [7:0] exp);
    @(posedge clock); #1;
    peek_addr = a;
    @(posedge clock); #1;
    check(name, peek_data, exp);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [7:0] rd;

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_ac", ac, 32'h0);
    check("reset_inc", {31'd0, inc_mode}, 32'd1);
    cyc = 0;
    while (busy === 1'b1 && cyc < CC + 50) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("clear_busy_cycles", cyc, CC);
    peek_chk("init_peek_00", 7'h00, 8'h20);
    peek_chk("init_peek_67", 7'h67, 8'h20);
    peek_chk("init_peek_unmapped", 7'h30, 8'h00);

    cmd(8'h38); cmd(8'h0C); cmd(8'h01); cmd(8'h06); cmd(8'h80);
    wr(8'h31); wr(8'h32);
    check("two_line", {31'd0, two_line}, 32'd1);
    check("display_on", {31'd0, display_on}, 32'd1);
    check("cursor_on", {31'd0, cursor_on}, 32'd0);
    check("inc_mode", {31'd0, inc_mode}, 32'd1);
    check("ac_after_text", ac, 32'h02);
    check("xfer_count_7", xfer_count, 32'd7);
    peek_chk("peek_00_31", 7'h00, 8'h31);
    peek_chk("peek_01_32", 7'h01, 8'h32);

    cmd(8'hA7); wr(8'h41); wr(8'h42);
    check("ac_wrap_up", ac, 32'h41);
    peek_chk("peek_27", 7'h27, 8'h41);
    peek_chk("peek_40", 7'h40, 8'h42);
    cmd(8'h04); cmd(8'h80); wr(8'h43);
    check("ac_wrap_down", ac, 32'h67);
    peek_chk("peek_00_43", 7'h00, 8'h43);

    wr(8'h44);
    xfer(1'b1, 1'b0, 8'h31);
    check("err_overrun", {31'd0, err_overrun}, 32'd1);
    check("overrun_xfer", xfer_count, 32'd14);
    check("overrun_ac", ac, 32'h66);
    peek_chk("overrun_peek", 7'h66, 8'h20);

    cmd(8'hA8);
    check("err_addr", {31'd0, err_addr}, 32'd1);
    check("bad_addr_ac", ac, 32'h00);
    wait_idle(CC + 20);
    on_i = 1'b0;
    xfer(1'b1, 1'b0, 8'h55);
    on_i = 1'b1;
    check("off_xfer", xfer_count, 32'd15);
    check("off_ac", ac, 32'h00);

    cmd(8'h06); cmd(8'h85); wr(8'h5A);
    read_xfer(1'b0, rd);
    check("read_status", rd, 32'h86);
    wait_idle(CC + 20);
    cmd(8'h85);
    wait_idle(CC + 20);
    read_xfer(1'b1, rd);
    check("read_data", rd, 32'h5A);
    check("read_ac_step", ac, 32'h06);

    for (int k = 0; k < 300; k++) begin
      int op, t;
      logic [7:0] d;
      op = $urandom_range(0, 99);
      peek_addr = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) wait_idle(CC + 20);
      else repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      if (op < 40) begin
        xfer(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      end else if (op < 70) begin
        t = $urandom_range(0, 8);
        d = 8'($urandom_range(0, 255));
        case (t)
          0: d = 8'h80 | d;
          1: d = 8'h40 | (d & 8'h3F);
          2: d = 8'h20 | (d & 8'h1F);
          3: d = 8'h10 | (d & 8'h0F);
          4: d = 8'h08 | (d & 8'h07);
          5: d = 8'h04 | (d & 8'h03);
          6: d = 8'h02 | (d & 8'h01);
          7: d = ($urandom_range(0, 2) == 0) ? 8'h01 : 8'h02;
          default: d = 8'h00;
        endcase
        xfer(1'b0, 1'b0, d);
      end else if (op < 85) begin
        read_xfer(1'($urandom_range(0, 1)), rd);
      end else if (op < 92) begin
        on_i = 1'b0;
        xfer(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        on_i = 1'b1;
      end else if (op < 95) begin
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
      end else begin
        xfer(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        xfer(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      end
    end
    wait_idle(CC + 20);
    repeat (2) @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
